// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, requester indices and defaults for the Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int M_FETCH = 0;
  localparam int M_LOAD = 1;
  localparam int M_STORE = 2;
  localparam int DEF_NUM_MASTERS = 3;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching upward from pointer+1
module rr_pick #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);
  always_comb begin
    o_gnt = '0;
    for (int i = N; i >= 1; i--) begin
      o_gnt = i_req[PW'((int'(i_ptr) + i) % N)] ? N'(1) << ((int'(i_ptr) + i) % N) : o_gnt;
    end
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter with per-cycle grant, response routing and bus watchdog
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc,
  input  logic [SW*NUM_MASTERS-1:0] i_m_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_we,
  input  logic [AW*NUM_MASTERS-1:0] i_m_addr,
  input  logic [DW*NUM_MASTERS-1:0] i_m_dat,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [DW-1:0]             o_m_dat,
  output logic                      o_wb_cyc,
  output logic [SW-1:0]             o_wb_stb,
  output logic                      o_wb_we,
  output logic [AW-1:0]             o_wb_addr,
  output logic [DW-1:0]             o_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  input  logic [DW-1:0]             i_wb_dat,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic                      o_timeout
);
  localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TOP = CW'(TIMEOUT);
  state_t state;
  logic [NUM_MASTERS-1:0] grant, sel, win;
  logic [PW-1:0] ptr, win_idx;
  logic win_vld;
  logic [CW-1:0] cnt;
  rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
    .i_req  (i_m_cyc),
    .i_ptr  (ptr),
    .o_gnt  (win),
    .o_valid(win_vld)
  );
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) win_idx = win[k] ? PW'(k) : win_idx;
  end
  assign sel = grant & i_m_cyc;
  always_comb begin
    o_wb_stb = '0;
    o_wb_we = 1'b0;
    o_wb_addr = '0;
    o_wb_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      o_wb_stb = o_wb_stb | (i_m_stb[SW*k +: SW] & {SW{sel[k]}});
      o_wb_we = o_wb_we | (i_m_we[k] & sel[k]);
      o_wb_addr = o_wb_addr | (i_m_addr[AW*k +: AW] & {AW{sel[k]}});
      o_wb_dat = o_wb_dat | (i_m_dat[DW*k +: DW] & {DW{sel[k]}});
    end
  end
  assign o_wb_cyc = |sel;
  assign o_timeout = (TIMEOUT != 0) && o_wb_cyc && !i_wb_ack && !i_wb_err && cnt == TOP;
  assign o_m_ack = sel & {NUM_MASTERS{i_wb_ack & ~i_wb_err}};
  assign o_m_err = sel & {NUM_MASTERS{i_wb_err | o_timeout}};
  assign o_m_dat = i_wb_dat;
  assign o_grant = grant;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      grant <= '0;
      ptr <= PW'(NUM_MASTERS - 1);
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (win_vld) begin
        grant <= win;
        ptr <= win_idx;
        state <= BUSY;
      end
    end else if (!o_wb_cyc) begin
      state <= IDLE;
      grant <= '0;
      cnt <= '0;
    end else begin
      cnt <= (i_wb_ack || i_wb_err || o_timeout) ? '0 : (|o_wb_stb && cnt != TOP) ? cnt + CW'(1) : cnt;
    end
  end
endmodule
